// File: rtl/jpeg_bitstream_burst_ctrl.sv
// Drain-side burst sequencer for the JPEG bitstream FIFO: full/partial bursts, frame word count.
// Optional idle-flush timeout enabled by defining JPEG_BSCTRL_TIMEOUT_EN.
module jpeg_bitstream_burst_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WL_WIDTH       = 13,
  parameter int unsigned BURST_LEN      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_rd_empty,
  input  logic [WL_WIDTH-1:0]   i_fifo_rd_water_level,
  input  logic                  i_frame_end,
  output logic                  o_burst_req,
  output logic [8:0]            o_burst_len,
  input  logic                  i_burst_ack,
  output logic                  o_wr_valid,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_last,
  input  logic                  i_wr_ready,
  output logic                  o_frame_done,
  output logic [23:0]           o_frame_words
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_t;

  localparam logic [8:0]          BurstLen   = 9'(BURST_LEN);
  localparam logic [WL_WIDTH-1:0] BurstLenWl = WL_WIDTH'(BURST_LEN);

  state_t                r_state, w_state_next;
  logic [8:0]            r_len, w_len_next;
  logic [8:0]            r_issued, r_sent;
  logic [1:0]            r_occ;
  logic                  r_rd_pending;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic [23:0]           r_word_cnt, r_frame_words;
  logic                  r_fe_latch;

  logic       w_wl_full, w_wl_nz, w_pop, w_timeout_hit;
  logic [2:0] w_fill;

  assign w_wl_full = i_fifo_rd_water_level >= BurstLenWl;
  assign w_wl_nz   = i_fifo_rd_water_level != '0;

  assign o_wr_valid = r_occ != 2'd0;
  assign o_wr_data  = r_buf0;
  assign o_wr_last  = o_wr_valid && (r_sent == r_len - 9'd1);
  assign w_pop      = o_wr_valid && i_wr_ready;

  // Occupancy after this cycle's pop plus the read landing next edge; keeps 1 beat/cycle
  // streaming while never letting a third word arrive into the 2-entry buffer.
  assign w_fill       = 3'(r_occ) + 3'(r_rd_pending) - 3'(w_pop);
  assign o_fifo_rd_en = (r_state == StXfer) && (w_fill < 3'd2) && (r_issued < r_len) &&
                        !i_fifo_rd_empty;

  assign o_burst_req   = r_state == StReq;
  assign o_burst_len   = r_len;
  assign o_frame_done  = r_state == StDone;
  assign o_frame_words = (r_state == StDone) ? r_word_cnt : r_frame_words;

`ifdef JPEG_BSCTRL_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] r_timer;
  logic              w_timer_run;

  assign w_timer_run   = (r_state == StIdle) && w_wl_nz && !w_wl_full && !r_fe_latch;
  assign w_timeout_hit = w_timer_run && (r_timer == TimerW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_timer_run && !w_timeout_hit) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    unique case (r_state)
      StIdle: begin
        if (w_wl_full) begin
          w_len_next   = BurstLen;
          w_state_next = StReq;
        end else if ((r_fe_latch && w_wl_nz) || w_timeout_hit) begin
          w_len_next   = 9'(i_fifo_rd_water_level);
          w_state_next = StReq;
        end else if (r_fe_latch && i_fifo_rd_empty) begin
          w_state_next = StDone;
        end
      end
      StReq:   if (i_burst_ack) w_state_next = StXfer;
      StXfer:  if (w_pop && o_wr_last) w_state_next = StIdle;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_len         <= '0;
      r_issued      <= '0;
      r_sent        <= '0;
      r_occ         <= '0;
      r_rd_pending  <= 1'b0;
      r_buf0        <= '0;
      r_buf1        <= '0;
      r_word_cnt    <= '0;
      r_frame_words <= '0;
      r_fe_latch    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_len        <= w_len_next;
      r_rd_pending <= o_fifo_rd_en;

      if (r_state == StReq && i_burst_ack) begin
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (o_fifo_rd_en) r_issued <= r_issued + 9'd1;
        if (w_pop)        r_sent   <= r_sent + 9'd1;
      end

      if (r_rd_pending && w_pop) begin
        if (r_occ == 2'd2) begin
          r_buf0 <= r_buf1;
          r_buf1 <= i_fifo_rd_data;
        end else begin
          r_buf0 <= i_fifo_rd_data;
        end
      end else if (w_pop) begin
        r_buf0 <= r_buf1;
      end else if (r_rd_pending) begin
        if (r_occ == 2'd0) r_buf0 <= i_fifo_rd_data;
        else               r_buf1 <= i_fifo_rd_data;
      end
      r_occ <= r_occ + 2'(r_rd_pending) - 2'(w_pop);

      if (r_state == StDone) begin
        r_word_cnt    <= '0;
        r_frame_words <= r_word_cnt;
      end else if (w_pop) begin
        r_word_cnt <= r_word_cnt + 24'd1;
      end

      // A frame_end arriving while DONE clears the latch must not be lost.
      if (i_frame_end)           r_fe_latch <= 1'b1;
      else if (r_state == StDone) r_fe_latch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_burst_ctrl.sv
// Scoreboard bench for jpeg_bitstream_burst_ctrl: behavioural FIFO, ack/ready drivers, monitor.
`timescale 1ns/1ps
module tb_jpeg_bitstream_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic [12:0] fifo_rd_water_level;
  logic        frame_end = 1'b0;
  logic        burst_req;
  logic [8:0]  burst_len;
  logic        burst_ack = 1'b0;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready = 1'b1;
  logic        frame_done;
  logic [23:0] frame_words;

  jpeg_bitstream_burst_ctrl #(
    .DATA_WIDTH     (32),
    .WL_WIDTH       (13),
    .BURST_LEN      (256),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .o_fifo_rd_en          (fifo_rd_en),
    .i_fifo_rd_data        (fifo_rd_data),
    .i_fifo_rd_empty       (fifo_rd_empty),
    .i_fifo_rd_water_level (fifo_rd_water_level),
    .i_frame_end           (frame_end),
    .o_burst_req           (burst_req),
    .o_burst_len           (burst_len),
    .i_burst_ack           (burst_ack),
    .o_wr_valid            (wr_valid),
    .o_wr_data             (wr_data),
    .o_wr_last             (wr_last),
    .i_wr_ready            (wr_ready),
    .o_frame_done          (frame_done),
    .o_frame_words         (frame_words)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: data appears the cycle after a read.
  logic [31:0] mem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned seq = 0;

  assign fifo_rd_water_level = 13'(wr_ptr - rd_ptr);
  assign fifo_rd_empty       = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[11:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  logic [31:0] exp_data_q[$];
  int          exp_len_q[$];
  int          exp_fw_q[$];

  int checks = 0;
  int failures = 0;
  int beat_cnt = 0;
  int cur_len = 0;
  int n_req = 0;
  int ack_delay = 1;
  bit rnd_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = {16'hC0DE ^ seq[15:0], seq[15:0]};
      mem[wr_ptr[11:0]] = v;
      exp_data_q.push_back(v);
      wr_ptr = wr_ptr + 1;
      seq    = seq + 1;
    end
  endtask

  task automatic pulse_frame_end();
    @(posedge clk); #1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_data_q.size() != 0 || exp_len_q.size() != 0 || exp_fw_q.size() != 0) &&
           n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      failures++;
      $display("FAIL %s drain: pending data=%0d bursts=%0d frames=%0d, need all 0", name,
               exp_data_q.size(), exp_len_q.size(), exp_fw_q.size());
    end
  endtask

  task automatic wait_beat(input string name, input int req_idx, input int beat);
    int n = 0;
    while (!(n_req == req_idx && beat_cnt >= beat) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s wait: reached req=%0d beat=%0d, need req=%0d beat=%0d", name, n_req,
               beat_cnt, req_idx, beat);
    end
  endtask

  // Downstream request acceptor: ack after ack_delay cycles of a held request.
  initial begin
    int req_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (burst_ack) begin
        burst_ack = 1'b0;
        req_cnt   = 0;
      end else if (burst_req && !rst) begin
        if (req_cnt >= ack_delay) burst_ack = 1'b1;
        else                      req_cnt++;
      end else begin
        req_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      wr_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: all output checks against the expectation queues.
  initial begin
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [8:0]  prev_len = '0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_cnt   = 0;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (fifo_rd_en) check("rd_en_while_empty", fifo_rd_empty, 1'b0);
        if (prev_req && !prev_ack) begin
          check("burst_req_held", burst_req, 1'b1);
          check("burst_len_stable", burst_len, prev_len);
        end
        if (prev_valid && !prev_ready) begin
          check("wr_valid_held", wr_valid, 1'b1);
          check("wr_data_stable", wr_data, prev_data);
        end
        if (burst_req && burst_ack) begin
          n_req++;
          beat_cnt = 0;
          if (exp_len_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL burst_len: unexpected request len=%0d, none expected", burst_len);
            cur_len = int'(burst_len);
          end else begin
            cur_len = exp_len_q.pop_front();
            check("burst_len", burst_len, cur_len);
          end
        end
        if (wr_valid && wr_ready) begin
          beat_cnt++;
          if (exp_data_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_data: unexpected beat 0x%0h, none expected", wr_data);
          end else begin
            check("wr_data", wr_data, exp_data_q.pop_front());
          end
          check("wr_last", wr_last, beat_cnt == cur_len);
        end
        if (frame_done) begin
          if (exp_fw_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_done: unexpected pulse words=%0d, none expected", frame_words);
          end else begin
            check("frame_words", frame_words, exp_fw_q.pop_front());
          end
        end
        prev_req   = burst_req;
        prev_ack   = burst_ack;
        prev_len   = burst_len;
        prev_valid = wr_valid;
        prev_ready = wr_ready;
        prev_data  = wr_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need test completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #2;
    check("reset_fifo_rd_en", fifo_rd_en, 1'b0);
    check("reset_burst_req", burst_req, 1'b0);
    check("reset_burst_len", burst_len, 9'd0);
    check("reset_wr_valid", wr_valid, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_frame_words", frame_words, 24'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single full burst, ack after 3 cycles.
    ack_delay = 3;
    exp_len_q.push_back(256);
    push_words(256);
    wait_drain("full_burst", 1000);
    exp_fw_q.push_back(256);
    pulse_frame_end();
    wait_drain("full_burst_done", 50);

    // 600 words then frame end: 256, 256, 88.
    ack_delay = 1;
    exp_len_q.push_back(256);
    exp_len_q.push_back(256);
    exp_len_q.push_back(88);
    exp_fw_q.push_back(600);
    push_words(600);
    pulse_frame_end();
    wait_drain("three_bursts", 2000);

    // Pseudo-random wr_ready backpressure.
    rnd_mode = 1'b1;
    exp_len_q.push_back(256);
    exp_fw_q.push_back(256);
    push_words(256);
    pulse_frame_end();
    wait_drain("random_ready", 3000);
    rnd_mode = 1'b0;

    // Frame end mid-burst leaves 10 words for a follow-up burst.
    n0 = n_req;
    exp_len_q.push_back(256);
    exp_len_q.push_back(10);
    exp_fw_q.push_back(266);
    push_words(266);
    wait_beat("mid_frame_end", n0 + 1, 50);
    pulse_frame_end();
    wait_drain("mid_frame_end", 1500);

    // Five words, idle: only the timeout build flushes without a frame end.
    n0 = n_req;
`ifdef JPEG_BSCTRL_TIMEOUT_EN
    exp_len_q.push_back(5);
    push_words(5);
    wait_drain("timeout_flush", 200);
    check("timeout_req_count", n_req - n0, 1);
    exp_fw_q.push_back(5);
    pulse_frame_end();
    wait_drain("timeout_done", 50);
`else
    push_words(5);
    repeat (100) @(posedge clk);
    #1;
    check("no_timeout_req_count", n_req - n0, 0);
    check("no_timeout_burst_req", burst_req, 1'b0);
    exp_len_q.push_back(5);
    exp_fw_q.push_back(5);
    pulse_frame_end();
    wait_drain("partial_flush", 100);
`endif

    // Reset mid-burst, then a clean frame.
    n0 = n_req;
    exp_len_q.push_back(256);
    push_words(256);
    wait_beat("reset_mid_burst", n0 + 1, 100);
    rst = 1'b1;
    #1;
    check("midrst_fifo_rd_en", fifo_rd_en, 1'b0);
    check("midrst_burst_req", burst_req, 1'b0);
    check("midrst_burst_len", burst_len, 9'd0);
    check("midrst_wr_valid", wr_valid, 1'b0);
    check("midrst_wr_data", wr_data, 32'd0);
    check("midrst_wr_last", wr_last, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_frame_words", frame_words, 24'd0);
    exp_data_q.delete();
    exp_len_q.delete();
    exp_fw_q.delete();
    wr_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_len_q.push_back(256);
    exp_fw_q.push_back(256);
    push_words(256);
    pulse_frame_end();
    wait_drain("after_reset", 1000);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
